// File: rtl/i2c_master_reader.sv
// I2C master that reads NUM_BYTES from one slave register, optionally after writing a pointer.
// Latency: busy one clk after trigger; data/data_valid on the clk busy falls, ~(29+)*CLK_DIV clks.
// Backpressure: none; triggers arriving while busy are dropped, never queued.
//
// Ports:
//   clk, reset_n          : system clock, asynchronous active-low reset
//   start, reg_ptr        : read request pulse and pointer byte (sampled on acceptance)
//   scl, sda              : I2C pins (scl push-pull, sda open-drain)
//   busy                  : transaction in progress
//   data, data_valid      : last good word (first byte in MSBs) and its update strobe
//   nack_err              : pulse when a transaction ends due to a slave NACK
module i2c_master_reader #(
    parameter int unsigned CLK_DIV     = 200,
    parameter logic [6:0]  DEV_ADDR    = 7'h48,
    parameter int unsigned NUM_BYTES   = 2,
    parameter int unsigned PTR_EN      = 0,
    parameter int unsigned POLL_CYCLES = 50_000_000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [7:0]             reg_ptr,
    output logic                   scl,
    inout  wire                    sda,
    output logic                   busy,
    output logic [8*NUM_BYTES-1:0] data,
    output logic                   data_valid,
    output logic                   nack_err
);

    localparam int DW = 8 * NUM_BYTES;
    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = $clog2(DW + 1);
    localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int Q  = CLK_DIV / 4;

    localparam logic [CW-1:0] CNT_Q   = CW'(Q);
    localparam logic [CW-1:0] CNT_2Q  = CW'(2 * Q);
    localparam logic [CW-1:0] CNT_3Q  = CW'(3 * Q);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] RD_BITS = BW'(DW);
    localparam logic [PW-1:0] POLL_MAX = (POLL_CYCLES > 0) ? PW'(POLL_CYCLES - 1) : '0;

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR_W, S_ACK_AW, S_PTR, S_ACK_P,
        S_RSTART, S_ADDR_R, S_ACK_AR, S_READ, S_MACK, S_STOP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [7:0]      ptr_q, ptr_d;
    logic [DW-1:0]   shadow_q, shadow_d;
    logic [DW-1:0]   data_q, data_d;
    logic            sda_oe_q, sda_oe_d;
    logic            ack_q, ack_d;
    logic            err_q, err_d;
    logic            dv_q, dv_d;
    logic            ne_q, ne_d;
    logic [PW-1:0]   poll_q, poll_d;

    logic            sda_in;
    logic            poll_wrap;
    logic            trig;
    logic            at_q, at_3q, end_bit;
    logic [7:0]      tx_byte;
    logic            tx_bit;
    logic            more_bytes;

    // Pad read directly: the master samples a quarter period after SCL rises,
    // which leaves ample settling time.
    assign sda_in = sda;
    assign sda    = sda_oe_q ? 1'b0 : 1'bz;

    // SCL held high in IDLE and START so the START is a clean SDA fall on an idle bus.
    assign scl        = (state_q == S_IDLE || state_q == S_START) ? 1'b1 : (cnt_q >= CNT_2Q);
    assign busy       = (state_q != S_IDLE);
    assign data       = data_q;
    assign data_valid = dv_q;
    assign nack_err   = ne_q;

    assign poll_wrap = (POLL_CYCLES != 0) && (poll_q == POLL_MAX);
    assign poll_d    = (poll_wrap || POLL_CYCLES == 0) ? '0 : poll_q + PW'(1);
    assign trig      = start | poll_wrap;

    assign at_q    = (cnt_q == CNT_Q);
    assign at_3q   = (cnt_q == CNT_3Q);
    assign end_bit = (cnt_q == CNT_MAX);

    always_comb begin
        tx_byte = ptr_q;
        if (state_q == S_ADDR_W) tx_byte = {DEV_ADDR, 1'b0};
        if (state_q == S_ADDR_R) tx_byte = {DEV_ADDR, 1'b1};
    end
    assign tx_bit     = tx_byte[~bit_q[2:0]];
    // bit_q counts every read bit of the transaction, so it reaches RD_BITS after the last byte.
    assign more_bytes = (bit_q != RD_BITS);

    always_comb begin
        state_d  = state_q;
        cnt_d    = (state_q == S_IDLE || end_bit) ? '0 : cnt_q + CW'(1);
        bit_d    = bit_q;
        ptr_d    = ptr_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        sda_oe_d = sda_oe_q;
        ack_d    = ack_q;
        err_d    = err_q;
        dv_d     = 1'b0;
        ne_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (trig) begin
                    state_d  = S_START;
                    ptr_d    = reg_ptr;
                    shadow_d = '0;
                    err_d    = 1'b0;
                    bit_d    = '0;
                end
            end
            S_START: begin
                if (at_3q) sda_oe_d = 1'b1;
                if (end_bit) begin
                    state_d = (PTR_EN != 0) ? S_ADDR_W : S_ADDR_R;
                    bit_d   = '0;
                end
            end
            S_ADDR_W, S_PTR, S_ADDR_R: begin
                if (at_q) sda_oe_d = ~tx_bit;
                if (end_bit) begin
                    if (bit_q[2:0] == 3'd7) begin
                        bit_d = '0;
                        case (state_q)
                            S_ADDR_W: state_d = S_ACK_AW;
                            S_PTR:    state_d = S_ACK_P;
                            default:  state_d = S_ACK_AR;
                        endcase
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            S_ACK_AW, S_ACK_P, S_ACK_AR: begin
                if (at_q)  sda_oe_d = 1'b0;
                if (at_3q) ack_d    = sda_in;
                if (end_bit) begin
                    if (ack_q) begin
                        state_d = S_STOP;
                        err_d   = 1'b1;
                    end else begin
                        case (state_q)
                            S_ACK_AW: state_d = S_PTR;
                            S_ACK_P:  state_d = S_RSTART;
                            default:  state_d = S_READ;
                        endcase
                    end
                end
            end
            S_RSTART: begin
                if (at_q)  sda_oe_d = 1'b0;
                if (at_3q) sda_oe_d = 1'b1;
                if (end_bit) begin
                    state_d = S_ADDR_R;
                    bit_d   = '0;
                end
            end
            S_READ: begin
                if (at_q)  sda_oe_d = 1'b0;
                if (at_3q) shadow_d = {shadow_q[DW-2:0], sda_in};
                if (end_bit) begin
                    bit_d = bit_q + BW'(1);
                    if (bit_q[2:0] == 3'd7) state_d = S_MACK;
                end
            end
            S_MACK: begin
                // ACK keeps the slave sending; NACK on the final byte tells it to stop.
                if (at_q) sda_oe_d = more_bytes;
                if (end_bit) state_d = more_bytes ? S_READ : S_STOP;
            end
            S_STOP: begin
                if (at_q)  sda_oe_d = 1'b1;
                if (at_3q) sda_oe_d = 1'b0;
                if (end_bit) begin
                    state_d = S_IDLE;
                    if (err_q) begin
                        ne_d = 1'b1;
                    end else begin
                        data_d = shadow_q;
                        dv_d   = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            ptr_q    <= '0;
            shadow_q <= '0;
            data_q   <= '0;
            sda_oe_q <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            dv_q     <= 1'b0;
            ne_q     <= 1'b0;
            poll_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            ptr_q    <= ptr_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            sda_oe_q <= sda_oe_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            dv_q     <= dv_d;
            ne_q     <= ne_d;
            poll_q   <= poll_d;
        end
    end

endmodule
